// File: rtl/operand_mult_unit.sv
// Sequential unsigned multiplier: operands are loaded one at a time, then go runs
// a DW-cycle shift-add loop (LSB first) and publishes the 2*DW-bit product with a done pulse.
module operand_mult_unit #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            sel,
    input  logic [DW-1:0]   data_in,
    input  logic            go,
    output logic            loaded_x,
    output logic            loaded_y,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] result
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            go_ok;
    logic            last;
    logic [DW-1:0]   x_reg;
    logic [DW-1:0]   y_reg;
    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] acc_add;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go_ok     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (go && loaded_x && loaded_y) begin
                    state_nxt = RUN;
                    go_ok     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CW'(DW - 1)) begin
                    state_nxt = IDLE;
                    last      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The running sum never exceeds the final product, so 2*DW bits cannot overflow.
    assign acc_add = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg    <= '0;
            y_reg    <= '0;
            loaded_x <= 1'b0;
            loaded_y <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go_ok) begin
                mcand  <= {{DW{1'b0}}, x_reg};
                mplier <= y_reg;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == IDLE && load) begin
                if (sel) begin
                    y_reg    <= data_in;
                    loaded_y <= 1'b1;
                end else begin
                    x_reg    <= data_in;
                    loaded_x <= 1'b1;
                end
            end
            if (state == RUN) begin
                acc    <= acc_add;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    result   <= acc_add;
                    done     <= 1'b1;
                    loaded_x <= 1'b0;
                    loaded_y <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule
